// File: rtl/ttt_turn_sequencer_if.sv
// rtl/ttt_turn_sequencer_if.sv - handshake/bus bundle between turn sequencer and game peripherals
interface ttt_turn_sequencer_if;
    logic       start;
    logic       player_first;
    logic [8:0] btn_n;
    logic [8:0] board_occ;
    logic       vnotactive;
    logic       cpu_done;
    logic [3:0] cpu_move;
    logic       judge_done;
    logic [1:0] judge_result;
    logic       cpu_start;
    logic       judge_start;
    logic       wr_en;
    logic [3:0] wr_idx;
    logic [1:0] wr_val;
    logic [2:0] game_state;
    logic       human_turn;

    modport slave (
        input  start, player_first, btn_n, board_occ, vnotactive,
               cpu_done, cpu_move, judge_done, judge_result,
        output cpu_start, judge_start, wr_en, wr_idx, wr_val, game_state, human_turn
    );

    modport master (
        output start, player_first, btn_n, board_occ, vnotactive,
               cpu_done, cpu_move, judge_done, judge_result,
        input  cpu_start, judge_start, wr_en, wr_idx, wr_val, game_state, human_turn
    );
endinterface

// File: rtl/ttt_turn_sequencer.sv
// rtl/ttt_turn_sequencer.sv - tic-tac-toe turn arbitration, blank-synchronised board writes, game state
module ttt_turn_sequencer #(
    parameter int CPU_TIMEOUT = 1023,
    parameter bit BLANK_SYNC  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ttt_turn_sequencer_if.slave   bus
);
    localparam int CW = $clog2(CPU_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, H_WAIT, H_WRITE, H_JUDGE, C_REQ, C_WAIT, C_WRITE, C_JUDGE, END_S
    } state_t;

    state_t        state_q;
    logic [CW-1:0] ctr_q;
    logic          cpu_start_q;
    logic          judge_start_q;
    logic          wr_en_q;
    logic [3:0]    wr_idx_q;
    logic [1:0]    wr_val_q;
    logic [2:0]    game_state_q;
    logic          human_turn_q;

    // Returns {found, index} of the lowest set bit; lowest index has priority.
    function automatic logic [4:0] lowest(input logic [8:0] v);
        logic [4:0] res;
        res = 5'd0;
        for (int i = 8; i >= 0; i--) begin
            if (v[i]) res = {1'b1, 4'(i)};
        end
        return res;
    endfunction

    logic [4:0]  press_pick;
    logic [4:0]  free_pick;
    logic [15:0] occ_ext;
    logic        cpu_ok;
    logic        wr_ok;
    logic        c_go;
    logic        c_have;
    logic [3:0]  c_idx;

    // Press/CPU move selection; indices 9..15 count as occupied so bad CPU moves fall back.
    always_comb begin
        press_pick = lowest(~bus.btn_n & ~bus.board_occ);
        free_pick  = lowest(~bus.board_occ);
        occ_ext    = {7'h7f, bus.board_occ};
        cpu_ok     = bus.cpu_done && !occ_ext[bus.cpu_move];
        wr_ok      = !BLANK_SYNC || bus.vnotactive;
        c_go       = bus.cpu_done || (ctr_q == CW'(CPU_TIMEOUT));
        c_have     = cpu_ok || free_pick[4];
        c_idx      = cpu_ok ? bus.cpu_move : free_pick[3:0];
    end

    // Game FSM; write strobe may assert on the accepting edge so a press reaches wr_en in one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            ctr_q         <= '0;
            cpu_start_q   <= 1'b0;
            judge_start_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_idx_q      <= 4'd0;
            wr_val_q      <= 2'b00;
            game_state_q  <= 3'd0;
            human_turn_q  <= 1'b0;
        end else begin
            cpu_start_q   <= 1'b0;
            judge_start_q <= 1'b0;
            wr_en_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        game_state_q <= 3'd1;
                        if (bus.player_first) begin
                            state_q      <= H_WAIT;
                            human_turn_q <= 1'b1;
                        end else begin
                            state_q <= C_REQ;
                        end
                    end
                end
                H_WAIT: begin
                    if (press_pick[4]) begin
                        wr_idx_q     <= press_pick[3:0];
                        wr_val_q     <= 2'b01;
                        human_turn_q <= 1'b0;
                        wr_en_q      <= wr_ok;
                        state_q      <= H_WRITE;
                    end
                end
                H_WRITE: begin
                    if (wr_en_q) begin
                        judge_start_q <= 1'b1;
                        state_q       <= H_JUDGE;
                    end else begin
                        wr_en_q <= wr_ok;
                    end
                end
                H_JUDGE: begin
                    if (bus.judge_done) begin
                        case (bus.judge_result)
                            2'b01: begin state_q <= END_S; game_state_q <= 3'd2; end
                            2'b11: begin state_q <= END_S; game_state_q <= 3'd4; end
                            default: state_q <= C_REQ;
                        endcase
                    end
                end
                C_REQ: begin
                    cpu_start_q <= 1'b1;
                    ctr_q       <= '0;
                    state_q     <= C_WAIT;
                end
                C_WAIT: begin
                    if (c_go) begin
                        if (c_have) begin
                            wr_idx_q <= c_idx;
                            wr_val_q <= 2'b10;
                            wr_en_q  <= wr_ok;
                            state_q  <= C_WRITE;
                        end else begin
                            state_q      <= END_S;
                            game_state_q <= 3'd4;
                        end
                    end else begin
                        ctr_q <= ctr_q + 1'b1;
                    end
                end
                C_WRITE: begin
                    if (wr_en_q) begin
                        judge_start_q <= 1'b1;
                        state_q       <= C_JUDGE;
                    end else begin
                        wr_en_q <= wr_ok;
                    end
                end
                C_JUDGE: begin
                    if (bus.judge_done) begin
                        case (bus.judge_result)
                            2'b10: begin state_q <= END_S; game_state_q <= 3'd3; end
                            2'b11: begin state_q <= END_S; game_state_q <= 3'd4; end
                            default: begin state_q <= H_WAIT; human_turn_q <= 1'b1; end
                        endcase
                    end
                end
                END_S: begin
                    if (bus.start) begin
                        state_q      <= IDLE;
                        game_state_q <= 3'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_start   = cpu_start_q;
    assign bus.judge_start = judge_start_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_idx      = wr_idx_q;
    assign bus.wr_val      = wr_val_q;
    assign bus.game_state  = game_state_q;
    assign bus.human_turn  = human_turn_q;
endmodule
